// File: rtl/inv_key_expansion.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_expansion
// Brief    : Iterative AES-128 decryption key scheduler. Runs the forward key
//            schedule from the cipher key up to round NUM_ROUNDS, then streams
//            the round keys back down to round 0 over a valid/ready port.
//            A single bank of four S-boxes serves both directions.
// Revision : 1.0 - initial release
// ============================================================================
module inv_key_expansion #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         done
);

    localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);

    // Rijndael S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic [127:0] r_key;
    logic [127:0] w_nextKey;
    logic [3:0]   r_rnd;
    logic [3:0]   w_nextRnd;
    logic         r_done;
    logic         w_nextDone;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_sboxIn;
    logic [31:0]  w_sboxOut;
    logic [3:0]   w_rconIdx;
    logic [31:0]  w_rcon;
    logic [31:0]  w_t;
    logic [127:0] w_fwdKey;
    logic [127:0] w_bwdKey;
    logic         w_handshake;

    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] sboxLookup(input logic [7:0] x);
        return c_SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] rconWord(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // Going backwards the S-box needs the previous round's w3, which is w2^w3
    // of the current key; going forwards it is simply w3.
    always_comb begin
        w_sboxIn  = rotWord(w_w3);
        w_rconIdx = r_rnd + 4'd1;
        if (r_state == EMIT) begin
            w_sboxIn  = rotWord(w_w2 ^ w_w3);
            w_rconIdx = r_rnd;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign w_sboxOut[8*i +: 8] = sboxLookup(w_sboxIn[8*i +: 8]);
    end

    assign w_rcon = rconWord(w_rconIdx);
    assign w_t    = w_sboxOut ^ w_rcon;

    // Both step directions computed from the shared t; the FSM picks one.
    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0 = w_w0 ^ w_t;
        f1 = w_w1 ^ f0;
        f2 = w_w2 ^ f1;
        f3 = w_w3 ^ f2;
        w_fwdKey = {f0, f1, f2, f3};
        w_bwdKey = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
    end

    assign w_handshake = (r_state == EMIT) && out_ready;

    // Next-state logic: load, ten forward steps, then reverse emission.
    always_comb begin
        w_nextState = r_state;
        w_nextKey   = r_key;
        w_nextRnd   = r_rnd;
        w_nextDone  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextKey   = key_in;
                    w_nextRnd   = 4'd0;
                    w_nextState = FORWARD;
                end
            end
            FORWARD: begin
                w_nextKey = w_fwdKey;
                w_nextRnd = r_rnd + 4'd1;
                if (r_rnd + 4'd1 == c_LAST_ROUND) begin
                    w_nextState = EMIT;
                end
            end
            EMIT: begin
                if (w_handshake) begin
                    if (r_rnd == 4'd0) begin
                        w_nextState = IDLE;
                        w_nextDone  = 1'b1;
                    end else begin
                        w_nextKey = w_bwdKey;
                        w_nextRnd = r_rnd - 4'd1;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_rnd   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_key   <= w_nextKey;
            r_rnd   <= w_nextRnd;
            r_done  <= w_nextDone;
        end
    end

    assign out_key   = r_key;
    assign out_round = r_rnd;
    assign out_valid = (r_state == EMIT);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_expansion.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_key_expansion
// Brief    : Self-checking bench for inv_key_expansion. A behavioural model
//            expands the key with a GF(2^8)-derived S-box and predicts every
//            output on every cycle; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_key_expansion;

    localparam int NR = 10;
    localparam logic [127:0] c_KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_R10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_R1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_R10_B = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] c_R1_B  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         out_valid;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         done;

    int checks = 0;
    int errors = 0;
    int hsCount = 0;
    int doneCount = 0;

    always #5 clk = ~clk;

    inv_key_expansion #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
        .done      (done)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [0:255];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] r1, r2, r3, r4;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) begin
                    inv = 8'(y);
                    break;
                end
            end
            r1 = rotl1(inv);
            r2 = rotl1(r1);
            r3 = rotl1(r2);
            r4 = rotl1(r3);
            sb[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    end

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    logic [127:0] mSched [0:10];
    int           mMode = 0;   // 0 idle, 1 expanding, 2 emitting
    int           mRnd = 0;
    bit           mDone = 1'b0;
    bit           mInit = 1'b0;
    logic [127:0] mKey = '0;

    task automatic expandKey(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) mSched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Model advances on each rising edge using the inputs held across it.
    always @(posedge clk) begin
        if (rst) begin
            mMode = 0; mRnd = 0; mDone = 1'b0; mKey = '0; mInit = 1'b1;
        end else if (mInit) begin
            mDone = 1'b0;
            case (mMode)
                0: if (start) begin
                    expandKey(key_in);
                    mKey = key_in; mRnd = 0; mMode = 1;
                end
                1: begin
                    mRnd++;
                    mKey = mSched[mRnd];
                    if (mRnd == NR) mMode = 2;
                end
                default: if (out_ready) begin
                    if (mRnd == 0) begin
                        mMode = 0; mDone = 1'b1;
                    end else begin
                        mRnd--;
                        mKey = mSched[mRnd];
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (mInit) begin
            check("cycle", {busy, out_valid, done, out_round, out_key},
                  {mMode != 0, mMode == 2, mDone, 4'(mRnd), mKey});
        end
        if (out_valid && out_ready && !rst) hsCount++;
        if (done) doneCount++;
    end

    // ---------------- stimulus ----------------
    task automatic runKey(input string tag, input logic [127:0] k, input int pct,
                          input bit noise, output int firstValid, output logic [127:0] firstKey);
        int n;
        int hs0;
        int dn0;
        hs0 = hsCount;
        dn0 = doneCount;
        start = 1'b1; key_in = k; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; firstValid = -1; firstKey = '0;
        while (!done && n < 400) begin
            if (out_valid && firstValid < 0) begin
                firstValid = n;
                firstKey   = out_key;
            end
            out_ready = ($urandom_range(0, 99) < pct);
            if (noise) begin
                start  = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; out_ready = 1'b0;
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_handshakes"}, hsCount - hs0, 11);
        @(posedge clk); #1;
        check({tag, "_done_pulses"}, doneCount - dn0, 1);
        check({tag, "_idle_after"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int fv;
        int n;
        logic [127:0] fk;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_state", {busy, out_valid, done, out_round, out_key}, '0);
        @(posedge clk); #1;

        // FIPS-197 App. A key at full rate
        runKey("fipsA", c_KEY_A, 100, 1'b0, fv, fk);
        check("fipsA_latency", fv, 10);
        check("fipsA_round10", fk, c_R10_A);
        check("model_A_r10", mSched[10], c_R10_A);
        check("model_A_r1", mSched[1], c_R1_A);
        check("model_A_r0", mSched[0], c_KEY_A);

        // Sequential key
        runKey("keyB", c_KEY_B, 100, 1'b0, fv, fk);
        check("keyB_latency", fv, 10);
        check("keyB_round10", fk, c_R10_B);
        check("model_B_r10", mSched[10], c_R10_B);
        check("model_B_r1", mSched[1], c_R1_B);

        // Random back-pressure
        runKey("stallA", c_KEY_A, 50, 1'b0, fv, fk);
        check("stallA_round10", fk, c_R10_A);

        // start/key_in toggled throughout FORWARD and EMIT
        runKey("noiseA", c_KEY_A, 70, 1'b1, fv, fk);
        check("noiseA_round10", fk, c_R10_A);

        // Random keys with random back-pressure
        for (int i = 0; i < 3; i++) begin
            runKey("randKey", {$urandom, $urandom, $urandom, $urandom}, 60, i[0], fv, fk);
        end

        // Reset while emitting round 5
        start = 1'b1; key_in = c_KEY_A; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_round == 4'd5) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_reached_r5", {out_valid, out_round}, {1'b1, 4'd5});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_outputs", {busy, out_valid, done, out_round, out_key}, '0);
        @(posedge clk); #1;
        check("rst_stays_idle", {busy, out_valid, done, out_round, out_key}, '0);
        runKey("afterRst", c_KEY_B, 100, 1'b0, fv, fk);
        check("afterRst_round10", fk, c_R10_B);

        // Back-to-back with start held high
        start = 1'b1; key_in = c_KEY_B; out_ready = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_run1_done", done, 1'b1);
        check("b2b_done_not_busy", busy, 1'b0);
        key_in = c_KEY_A;
        @(posedge clk); #1;
        check("b2b_accept", {busy, done, out_valid}, 3'b100);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_latency", n, 10);
        check("b2b_round10", {out_round, out_key}, {4'd10, c_R10_A});
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_run2_done", done, 1'b1);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
